// File: rtl/dsram_like_responder.sv
// dsram_like_responder: SRAM-like data-side slave with fixed-latency, in-order responses
// and a bounded number of outstanding transactions.
module dsram_like_responder #(
    parameter int ADDR_W    = 10,
    parameter int LATENCY   = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        addr_stall,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic [2:0]  outst_cnt
);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [31:0]          mem [2**ADDR_W];
    logic [MAX_OUTST-1:0] vld;
    logic [MAX_OUTST-1:0] is_wr;
    logic [31:0]          dat [MAX_OUTST];
    logic [3:0]           age [MAX_OUTST];
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [2:0]           cnt;
    logic [31:0]          last_rdata;
    logic [ADDR_W-1:0]    idx;
    logic                 accept;
    logic                 unused_bits;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign idx         = addr[ADDR_W+1:2];
    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};
    // Depends only on the registered count, so a same-cycle pop never reopens the port.
    assign addr_ok     = resetn & ~addr_stall & (cnt < 3'(MAX_OUTST));
    assign accept      = req & addr_ok;
    assign data_ok     = vld[rd_ptr] && (age[rd_ptr] == LAT);
    assign rdata       = data_ok ? (is_wr[rd_ptr] ? '0 : dat[rd_ptr]) : last_rdata;
    assign outst_cnt   = cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            last_rdata <= '0;
        end else begin
            if (data_ok) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= nxt(rd_ptr);
                last_rdata  <= rdata;
            end
            if (accept) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= nxt(wr_ptr);
            end
            cnt <= cnt + 3'(accept) - 3'(data_ok);
        end
    end

    // Payload and memory carry no reset; validity alone gates them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTST; i++)
            if (vld[i] && age[i] != LAT) age[i] <= age[i] + 4'd1;
        if (accept) begin
            is_wr[wr_ptr] <= wr;
            dat[wr_ptr]   <= mem[idx];
            age[wr_ptr]   <= 4'd1;
            if (wr)
                for (int k = 0; k < 4; k++)
                    if (wstrb[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
        end
    end
endmodule

// File: tb/tb_dsram_like_responder.sv
// tb_dsram_like_responder: random and directed traffic against a transaction-level
// model of memory contents and response timing.
module tb_dsram_like_responder;
    localparam int AW  = 10;
    localparam int LAT = 4;
    localparam int MO  = 2;

    logic        clk = 0, resetn = 0, req = 0, wr = 0, addr_stall = 0;
    logic [1:0]  size = 2'd2;
    logic [3:0]  wstrb = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic [2:0]  outst_cnt;

    dsram_like_responder #(.ADDR_W(AW), .LATENCY(LAT), .MAX_OUTST(MO)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_stall(addr_stall), .addr_ok(addr_ok),
        .data_ok(data_ok), .rdata(rdata), .outst_cnt(outst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; int t; } rsp_t;
    rsp_t        q[$];
    logic [31:0] mref [2**AW];
    logic [31:0] last_rd = 0;
    int          n = 0, n_chk = 0, n_fail = 0;
    bit          rnd_stall = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: inputs already driven at the preceding negedge.
    task automatic cycle(output bit acc);
        bit exp_aok, exp_dok;
        logic [AW-1:0] w;
        #1;
        exp_aok = !addr_stall && q.size() < MO;
        chk("addr_ok", addr_ok, exp_aok);
        acc = req && exp_aok;
        if (acc) begin
            w = addr[AW+1:2];
            if (wr)
                for (int k = 0; k < 4; k++) if (wstrb[k]) mref[w][8*k +: 8] = wdata[8*k +: 8];
            q.push_back('{d: wr ? 32'h0 : mref[w], t: n + 1});
        end
        @(posedge clk);
        n++;
        #1;
        while (q.size() > 0 && q[0].t + LAT <= n) void'(q.pop_front());
        chk("outst_cnt", outst_cnt, q.size());
        exp_dok = q.size() > 0 && q[0].t + LAT - 1 == n;
        chk("data_ok", data_ok, exp_dok);
        if (exp_dok) begin
            chk("rdata", rdata, q[0].d);
            last_rd = q[0].d;
        end else chk("rdata_hold", rdata, last_rd);
        @(negedge clk);
    endtask

    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit acc = 0;
        req = 1; wr = w; addr = a; wdata = d; wstrb = s;
        for (int i = 0; i < 40 && !acc; i++) begin
            addr_stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            cycle(acc);
        end
        if (!acc) chk("accept_timeout", 0, 1);
        addr_stall = 0;
    endtask

    task automatic idle(input int c);
        bit acc;
        req = 0;
        for (int i = 0; i < c; i++) cycle(acc);
    endtask

    initial begin
        bit acc;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr_ok", addr_ok, 0);
        chk("rst_data_ok", data_ok, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_outst", outst_cnt, 0);
        @(negedge clk);
        resetn = 1;
        idle(2);

        for (int i = 0; i < 16; i++) xfer(1, i * 4, $urandom, 4'hF);
        idle(LAT);

        xfer(1, 32'h100, 32'hDEADBEEF, 4'hF);
        idle(LAT + 1);
        xfer(0, 32'h100, 0, 0);
        idle(LAT + 1);

        xfer(1, 32'h200, 32'h11223344, 4'hF);
        xfer(1, 32'h200, 32'hAAAAAAAA, 4'b0100);
        xfer(0, 32'h200, 0, 0);
        idle(LAT + 1);
        chk("strobe_model", mref[128], 32'h11AA3344);
        xfer(1, 32'h200, 32'h55555555, 4'h0);
        xfer(0, 32'h200, 0, 0);
        idle(LAT + 1);

        xfer(0, 32'h0, 0, 0);
        xfer(0, 32'h4, 0, 0);
        xfer(0, 32'h8, 0, 0);
        idle(LAT + 2);

        addr_stall = 1; req = 1; wr = 1; addr = 32'h14; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        for (int i = 0; i < 3; i++) cycle(acc);
        addr_stall = 0;
        cycle(acc);
        chk("accept_after_stall", acc, 1);
        xfer(0, 32'h14, 0, 0);
        idle(LAT + 1);

        xfer(0, 32'h0, 0, 0);
        xfer(0, 32'h4, 0, 0);
        req = 0;
        resetn = 0;
        #1;
        chk("midrst_outst", outst_cnt, 0);
        chk("midrst_data_ok", data_ok, 0);
        chk("midrst_addr_ok", addr_ok, 0);
        chk("midrst_rdata", rdata, 0);
        q.delete();
        last_rd = 0;
        @(negedge clk);
        resetn = 1;
        idle(10);

        rnd_stall = 1;
        for (int i = 0; i < 300; i++) begin
            xfer($urandom_range(0, 1),
                 ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)),
                 $urandom, 4'($urandom));
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
        end
        idle(LAT + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
